// File: rtl/spi_cmd_scheduler_pkg.sv
// Shared opcodes, FSM state type and frame field positions for the SPI command scheduler.
package spi_cmd_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    localparam int unsigned CMD_MSB  = 23;
    localparam int unsigned CMD_LSB  = 16;
    localparam int unsigned ADDR_MSB = 15;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT_ACK
    } state_t;

endpackage

// File: rtl/spi_cmd_scheduler_fifo.sv
// Synchronous frame FIFO; pointers carry an extra wrap bit to tell full from empty.
module frame_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Turns queued SPI command frames into register-bus transactions with ack/timeout handling.
module spi_cmd_scheduler
    import spi_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] frame_in,
    input  logic        frame_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  rdata_out,
    output logic        rdata_valid,
    output logic        bad_cmd,
    output logic        timeout,
    output logic [7:0]  overflow_cnt,
    output logic        busy
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [23:0] cmd_q;
    logic [23:0] fifo_dout;
    logic        fifo_full, fifo_empty;
    logic        pop, push;
    logic        issue, ack_done, to_done;
    logic [7:0]  wait_cnt;
    logic [7:0]  opcode;

    assign opcode = cmd_q[CMD_MSB:CMD_LSB];
    assign pop    = (state == IDLE) && !fifo_empty;
    // A push while full still lands when the head is leaving in the same cycle.
    assign push   = frame_valid && (!fifo_full || pop);
    assign busy   = !fifo_empty || (state != IDLE);

    frame_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(24)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (frame_in),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        ack_done   = 1'b0;
        to_done    = 1'b0;
        bad_cmd    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = DECODE;
            end
            DECODE: begin
                state_next = IDLE;
                if (opcode == OP_WRITE || opcode == OP_READ) begin
                    issue      = 1'b1;
                    state_next = WAIT_ACK;
                end else if (opcode != OP_NOP) begin
                    bad_cmd = 1'b1;
                end
            end
            WAIT_ACK: begin
                // Ack has priority over a timeout landing in the same cycle.
                if (bus_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == TO_LAST) begin
                    to_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q        <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            rdata_out    <= '0;
            rdata_valid  <= 1'b0;
            timeout      <= 1'b0;
            wait_cnt     <= '0;
            overflow_cnt <= '0;
        end else begin
            rdata_valid <= 1'b0;
            timeout     <= 1'b0;
            if (pop) cmd_q <= fifo_dout;
            if (issue) begin
                bus_req   <= 1'b1;
                bus_we    <= (opcode == OP_WRITE);
                bus_addr  <= cmd_q[ADDR_MSB:ADDR_LSB];
                bus_wdata <= cmd_q[DATA_MSB:DATA_LSB];
                wait_cnt  <= '0;
            end
            if (state == WAIT_ACK && !bus_ack) wait_cnt <= wait_cnt + 1'b1;
            if (ack_done) begin
                bus_req <= 1'b0;
                if (!bus_we) begin
                    rdata_out   <= bus_rdata;
                    rdata_valid <= 1'b1;
                end
            end
            if (to_done) begin
                bus_req <= 1'b0;
                timeout <= 1'b1;
            end
            if (frame_valid && fifo_full && !pop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Bench for spi_cmd_scheduler: directed cases with literal expectations plus a randomized run
// compared every cycle against a timestamp-based transaction model.
module tb_spi_cmd_scheduler;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;
    localparam int          NEVER = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] frame_in;
    logic        frame_valid;
    logic        bus_req, bus_we;
    logic [7:0]  bus_addr, bus_wdata;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic [7:0]  rdata_out;
    logic        rdata_valid, bad_cmd, timeout;
    logic [7:0]  overflow_cnt;
    logic        busy;

    spi_cmd_scheduler #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .bad_cmd     (bad_cmd),
        .timeout     (timeout),
        .overflow_cnt(overflow_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge-indexed timeline. A frame can be popped at edge t once
    // t >= ready_t; a legal command then requests from edge t+1 until an ack or
    // TIMEOUT edges later, and the next pop may follow one edge after that.
    int          t = 0;
    logic [23:0] mq[$];
    int          ready_t = 0;
    bit          req_on = 1'b0;
    int          req_start = 0;
    logic [23:0] cur = '0;
    logic [7:0]  m_rdata = '0;
    bit          m_rvalid = 1'b0, m_to = 1'b0, m_bad = 1'b0;
    int          m_ovf = 0;

    function automatic bit e_req();
        return req_on && (t >= req_start);
    endfunction

    function automatic bit e_busy();
        return (mq.size() > 0) || (ready_t > t + 1);
    endfunction

    task automatic model_reset();
        mq.delete();
        ready_t  = 0;
        req_on   = 1'b0;
        cur      = '0;
        m_rdata  = '0;
        m_rvalid = 1'b0;
        m_to     = 1'b0;
        m_bad    = 1'b0;
        m_ovf    = 0;
    endtask

    task automatic model_step();
        bit         popped;
        logic [7:0] op;
        t++;
        m_rvalid = 1'b0;
        m_to     = 1'b0;
        m_bad    = 1'b0;
        if (req_on && t > req_start) begin
            if (bus_ack) begin
                req_on  = 1'b0;
                ready_t = t + 1;
                if (cur[23:16] == 8'h02) begin
                    m_rdata  = bus_rdata;
                    m_rvalid = 1'b1;
                end
            end else if (t == req_start + int'(TMO)) begin
                req_on  = 1'b0;
                m_to    = 1'b1;
                ready_t = t + 1;
            end
        end
        popped = 1'b0;
        if (t >= ready_t && mq.size() > 0) begin
            cur    = mq.pop_front();
            popped = 1'b1;
            op     = cur[23:16];
            if (op == 8'h01 || op == 8'h02) begin
                req_on    = 1'b1;
                req_start = t + 1;
                ready_t   = NEVER;
            end else begin
                ready_t = t + 2;
                m_bad   = (op != 8'h00);
            end
        end
        if (frame_valid) begin
            if (mq.size() < int'(DEPTH)) mq.push_back(frame_in);
            else if (m_ovf < 255) m_ovf++;
        end
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        chk("bus_req", bus_req, e_req());
        chk("busy", busy, e_busy());
        chk("bad_cmd", bad_cmd, m_bad);
        chk("timeout", timeout, m_to);
        chk("rdata_valid", rdata_valid, m_rvalid);
        chk("rdata_out", rdata_out, m_rdata);
        chk("overflow_cnt", overflow_cnt, m_ovf);
        if (e_req()) begin
            chk("bus_we", bus_we, cur[23:16] == 8'h01);
            chk("bus_addr", bus_addr, cur[15:8]);
            if (cur[23:16] == 8'h01) chk("bus_wdata", bus_wdata, cur[7:0]);
        end
    end

    // Ack policy: 0 random, 1 ack once the request is ack_delay cycles old, 2 never.
    int         ack_mode  = 2;
    int         ack_delay = 0;
    int         ack_pct   = 35;
    logic [7:0] rdata_fix = 8'h00;

    always @(negedge clk) begin
        if (reset)              bus_ack = 1'b0;
        else if (ack_mode == 0) bus_ack = e_req() ? ($urandom_range(0, 99) < ack_pct)
                                                  : ($urandom_range(0, 99) < 5);
        else if (ack_mode == 1) bus_ack = e_req() && ((t - req_start) >= ack_delay);
        else                    bus_ack = 1'b0;
        bus_rdata = (ack_mode == 0) ? 8'($urandom) : rdata_fix;
    end

    task automatic send(input logic [23:0] f);
        @(negedge clk);
        frame_valid = 1'b1;
        frame_in    = f;
    endtask

    task automatic end_send();
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bus_req && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || bus_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle", busy, 1'b0);
    endtask

    int         n, hi, cnt_a, cnt_b;
    logic [7:0] seen_addr[8];
    logic [7:0] seen_data[8];
    bit         prev_req;

    initial begin
        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_in    = '0;
        bus_ack     = 1'b0;
        bus_rdata   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_overflow", overflow_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata_out", rdata_out, 0);
        reset = 1'b0;

        // Single write, ack one cycle after the request rises.
        ack_mode = 1; ack_delay = 1;
        send(24'h0110A5);
        end_send();
        wait_req(n);
        chk("w_latency", n, 2);
        chk("w_we", bus_we, 1);
        chk("w_addr", bus_addr, 8'h10);
        chk("w_wdata", bus_wdata, 8'hA5);
        hi = 0;
        while (bus_req && hi < 20) begin hi++; @(negedge clk); end
        chk("w_req_len", hi, 2);
        cnt_a = 0;
        repeat (6) begin @(negedge clk); if (bus_req) cnt_a++; end
        chk("w_no_more_req", cnt_a, 0);
        chk("w_busy_after", busy, 0);

        // Read with three wait cycles.
        ack_delay = 3; rdata_fix = 8'h5C;
        send(24'h022000);
        end_send();
        wait_req(n);
        hi = 0; cnt_a = 0;
        while (bus_req && hi < 20) begin
            hi++;
            if (bus_we) cnt_a++;
            @(negedge clk);
        end
        chk("r_req_len", hi, 4);
        chk("r_we_cycles", cnt_a, 0);
        chk("r_rvalid", rdata_valid, 1);
        chk("r_rdata", rdata_out, 8'h5C);
        @(negedge clk);
        chk("r_rvalid_pulse", rdata_valid, 0);
        wait_idle();

        // Burst of six writes with no ack: one in flight, four queued, one dropped.
        ack_mode = 2;
        for (int i = 0; i < 6; i++) send({8'h01, 8'(i), 8'(8'h30 + i)});
        end_send();
        chk("burst_overflow", overflow_cnt, 1);
        chk("burst_busy", busy, 1);
        ack_mode = 1; ack_delay = 0;
        cnt_b = 0; prev_req = bus_req;
        repeat (60) begin
            @(negedge clk);
            if (bus_req && !prev_req && cnt_b < 8) begin
                seen_addr[cnt_b] = bus_addr;
                seen_data[cnt_b] = bus_wdata;
                cnt_b++;
            end
            prev_req = bus_req;
        end
        chk("burst_count", cnt_b, 4);
        for (int i = 0; i < 4; i++) begin
            chk("burst_addr", seen_addr[i], 8'(i + 1));
            chk("burst_data", seen_data[i], 8'(8'h31 + i));
        end
        wait_idle();

        // Timeout: request held TMO cycles, then the next frame issues.
        ack_mode = 2;
        send(24'h014011);
        send(24'h014122);
        end_send();
        wait_req(n);
        hi = 0;
        while (bus_req && hi < 40) begin hi++; @(negedge clk); end
        chk("to_req_len", hi, TMO);
        chk("to_pulse", timeout, 1);
        @(negedge clk);
        chk("to_pulse_end", timeout, 0);
        wait_req(n);
        chk("to_next_req", bus_req, 1);
        chk("to_next_addr", bus_addr, 8'h41);
        wait_idle();

        // Illegal opcode then NOP.
        send(24'h7F0000);
        send(24'h000000);
        end_send();
        cnt_a = 0; cnt_b = 0;
        if (bad_cmd) cnt_a++;
        repeat (10) begin
            @(negedge clk);
            if (bad_cmd) cnt_a++;
            if (bus_req) cnt_b++;
        end
        chk("bad_pulses", cnt_a, 1);
        chk("bad_req_cycles", cnt_b, 0);
        chk("bad_busy", busy, 0);

        // Reset in WAIT_ACK with two frames queued.
        ack_mode = 2;
        send(24'h015001);
        send(24'h015102);
        send(24'h015203);
        end_send();
        wait_req(n);
        chk("rst_pre_req", bus_req, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_async_req", bus_req, 0);
        chk("rst_async_ovf", overflow_cnt, 0);
        chk("rst_async_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ack_mode = 0;
        cnt_a = 0;
        repeat (20) begin @(negedge clk); if (bus_req) cnt_a++; end
        chk("rst_no_activity", cnt_a, 0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int ph = 0; ph < 3; ph++) begin
            int fv_pct;
            fv_pct  = (ph == 0) ? 20 : (ph == 1) ? 60 : 90;
            ack_pct = (ph == 2) ? 4 : 35;
            repeat (1000) begin
                int         sel;
                logic [7:0] op;
                @(negedge clk);
                sel = $urandom_range(0, 99);
                op  = (sel < 40) ? 8'h01 : (sel < 70) ? 8'h02 : (sel < 85) ? 8'h00 : 8'($urandom);
                frame_valid = ($urandom_range(0, 99) < fv_pct);
                frame_in    = {op, 8'($urandom), 8'($urandom)};
            end
        end
        end_send();
        ack_mode = 1; ack_delay = 0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_cmd_scheduler.md
# spi_cmd_scheduler

Consumes 24-bit SPI command frames from the SPI receive path and turns them into register-bus transactions on the ASIC's configuration register bank. Frames are buffered in a small FIFO so back-to-back SPI frames are never lost while a bus transaction is in flight. A command FSM decodes each frame, issues one bus access with a req/ack handshake and timeout, and reports readback data, errors and drop counts.

## Interface
Parameters:
- FIFO_DEPTH, 4: frame FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255: maximum cycles `bus_req` waits for `bus_ack`; minimum 1, maximum 255.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears FSM, FIFO pointers, counters and outputs.
- frame_in  in  24  {cmd[23:16], addr[15:8], data[7:0]}.
- frame_valid  in  1  one-cycle pulse; `frame_in` is valid this cycle.
- bus_req  out  1  transaction request; held until ack or timeout.
- bus_we  out  1  1 = write, 0 = read; stable while `bus_req`.
- bus_addr  out  8  register address; stable while `bus_req`.
- bus_wdata  out  8  write data; stable while `bus_req`.
- bus_ack  in  1  one-cycle completion strobe from the register bank.
- bus_rdata  in  8  read data; sampled in the cycle `bus_ack` is high.
- rdata_out  out  8  last read result; holds until the next read completes.
- rdata_valid  out  1  one-cycle pulse when `rdata_out` updates.
- bad_cmd  out  1  one-cycle pulse when an illegal opcode is discarded.
- timeout  out  1  one-cycle pulse when a transaction is abandoned.
- overflow_cnt  out  8  frames dropped because the FIFO was full; saturates at 255.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.

Reset values: all outputs 0.

## Operation
- Opcodes:
  - 0x00 NOP: pop and discard, no bus access.
  - 0x01 WRITE: bus write of `data` to `addr`.
  - 0x02 READ: bus read from `addr`; `data` is ignored.
  - Any other opcode: pop, pulse `bad_cmd`, no bus access.
- FIFO:
  - Push on `frame_valid`.
  - Pop when the FSM is in IDLE and the FIFO is non-empty.
  - Push while full with no pop in the same cycle: frame dropped, `overflow_cnt` +1 (saturating).
  - Push and pop in the same cycle while full: both succeed, nothing dropped.
  - Pointers wrap modulo FIFO_DEPTH. An extra wrap bit distinguishes full from empty.
- FSM states: IDLE, DECODE, WAIT_ACK.
  - IDLE: if the FIFO is non-empty, pop the head into the command register and go to DECODE.
  - DECODE:
    - WRITE/READ: assert `bus_req`, load `bus_we`/`bus_addr`/`bus_wdata`, clear the timeout counter, go to WAIT_ACK.
    - NOP: go to IDLE.
    - Illegal opcode: pulse `bad_cmd`, go to IDLE.
  - WAIT_ACK:
    - On `bus_ack`: deassert `bus_req` next cycle. For a READ, capture `bus_rdata` into `rdata_out` and pulse `rdata_valid`. Go to IDLE.
    - Otherwise the counter increments. When it reaches TIMEOUT: deassert `bus_req`, pulse `timeout`, go to IDLE.
    - Ack and timeout in the same cycle: the ack wins.
- `bus_ack` outside WAIT_ACK is ignored.
- `reset` asserted mid-transaction: `bus_req` drops immediately (asynchronous) and queued frames are lost.

## Timing
- Latency, empty FIFO and idle FSM:
  - `frame_valid` at cycle N: FIFO write at the N edge.
  - Pop into the command register at N+1.
  - `bus_req` high from N+2.
- An ack with `bus_req` first high at cycle M (ack in cycle M): `bus_req` low at M+1, FSM in IDLE at M+1. The next pop is at M+1 and the next `bus_req` at M+3.
- Throughput: one bus transaction per 3 cycles at best (zero-wait ack).
- Timeout: `bus_req` high for exactly TIMEOUT cycles, then `timeout` pulses in the cycle `bus_req` falls.
- `rdata_valid` and `rdata_out` update in the cycle after the ack.
- `bad_cmd` pulses in the DECODE cycle.

## Structure
- Package `spi_cmd_pkg`:
  - opcode constants OP_NOP, OP_WRITE, OP_READ;
  - FSM state typedef;
  - frame field bit-position constants.
- Sub-module `frame_fifo`: synchronous FIFO, 24-bit wide and FIFO_DEPTH deep. Ports: push, pop, din, dout, full, empty.
- Everything else lives in the top module.

## Test plan
- WRITE frame 0x01_10_A5, `bus_ack` 1 cycle after req: exactly one `bus_req` with we=1, addr=0x10, wdata=0xA5. `bus_req` rises 2 cycles after `frame_valid`. `busy` is low afterwards.
- READ frame 0x02_20_00, ack with `bus_rdata`=0x5C after 3 wait cycles: `rdata_out`=0x5C, one `rdata_valid` pulse, `bus_we`=0 throughout.
- Burst, FIFO_DEPTH=4, `bus_ack` held low: 6 WRITE frames on consecutive cycles. Expect 1 frame in flight, 4 queued, `overflow_cnt`=1. After acking, the remaining 4 writes occur in arrival order.
- Never ack, TIMEOUT=8: `bus_req` high exactly 8 cycles, then a `timeout` pulse, then the next queued frame issues.
- Frames 0x7F_00_00 then 0x00_00_00: one `bad_cmd` pulse, no `bus_req`, FIFO empty, FSM IDLE.
- `reset` asserted during WAIT_ACK with 2 frames queued: `bus_req`=0 asynchronously and `overflow_cnt`=0. No further bus activity after release.
